// File: rtl/pipelined_alu_hs.sv
// pipelined_alu_hs: 8-op WIDTH-bit ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish on the accept edge. DIV/MOD use a restoring divider
// that spends exactly WIDTH cycles in CALC. Only one operation is in flight.
module pipelined_alu_hs #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             div0
);

    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [2:0] OP_XOR  = 3'd0;
    localparam logic [2:0] OP_SHL  = 3'd1;
    localparam logic [2:0] OP_MOD  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_SHR  = 3'd4;
    localparam logic [2:0] OP_ADD  = 3'd5;
    localparam logic [2:0] OP_SUB  = 3'd6;
    localparam logic [2:0] OP_DIV  = 3'd7;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_d;
    logic             carry_d, div0_d;

    logic             accept;
    logic [WIDTH:0]   sum, diff, trial;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic [WIDTH-1:0] rem_step, quo_step;
    logic             big_shift;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    assign sum       = {1'b0, a} + {1'b0, b};
    assign diff      = {1'b0, a} - {1'b0, b};
    assign big_shift = (b >= WIDTH'(WIDTH));

    // Single-cycle result computed straight from the operands on the accept edge
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            OP_XOR:  alu_res = a ^ b;
            OP_SHL:  alu_res = big_shift ? '0 : (a << b);
            OP_NAND: alu_res = ~(a & b);
            OP_SHR:  alu_res = big_shift ? '0 : (a >> b);
            OP_ADD:  begin alu_res = sum[WIDTH-1:0];  alu_carry = sum[WIDTH];  end
            OP_SUB:  begin alu_res = diff[WIDTH-1:0]; alu_carry = diff[WIDTH]; end
            default: alu_res = '0;
        endcase
    end

    // One restoring-divider iteration: shift in next dividend bit, trial-subtract B
    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, b_q};
        if (trial[WIDTH]) begin
            rem_step = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_step = trial[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state;
        op_d    = op_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        out_d   = out;
        carry_d = carry;
        div0_d  = div0;
        case (state)
            IDLE: begin
                if (accept) begin
                    op_d = op;
                    b_d  = b;
                    if (op == OP_DIV || op == OP_MOD) begin
                        if (b == '0) begin
                            state_d = DONE;
                            out_d   = (op == OP_DIV) ? '1 : a;
                            carry_d = 1'b0;
                            div0_d  = 1'b1;
                        end else begin
                            state_d = CALC;
                            rem_d   = '0;
                            quo_d   = a;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = DONE;
                        out_d   = alu_res;
                        carry_d = alu_carry;
                        div0_d  = 1'b0;
                    end
                end
            end
            CALC: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    out_d   = (op_q == OP_DIV) ? quo_step : rem_step;
                    carry_d = 1'b0;
                    div0_d  = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= '0;
            b_q   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            out   <= '0;
            carry <= 1'b0;
            div0  <= 1'b0;
        end else begin
            state <= state_d;
            op_q  <= op_d;
            b_q   <= b_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
            out   <= out_d;
            carry <= carry_d;
            div0  <= div0_d;
        end
    end

endmodule

// File: tb/tb_pipelined_alu_hs.sv
// Directed self-checking bench for pipelined_alu_hs at WIDTH=8.
module tb_pipelined_alu_hs;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             div0;

    int total  = 0;
    int passed = 0;

    pipelined_alu_hs #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .carry     (carry),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Present one operation at a negedge, accept on the next posedge, then scramble inputs
    task automatic issue(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op = o;
        a  = av;
        b  = bv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom);
        a  = 8'($urandom);
        b  = 8'($urandom);
    endtask

    // Wait (bounded) for out_valid; check latency, in_ready low meanwhile, and payload
    task automatic expect_result(input string tag, input int lat_exp,
                                 input logic [7:0] out_exp, input logic c_exp,
                                 input logic d_exp);
        int  lat;
        bit  ready_seen;
        lat = 0;
        ready_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) ready_seen = 1'b1;
        end while (!out_valid && lat < 40);
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        check({tag, "_in_ready_low"}, 32'(ready_seen), 32'd0);
        check({tag, "_out"}, 32'(out), 32'(out_exp));
        check({tag, "_carry"}, 32'(carry), 32'(c_exp));
        check({tag, "_div0"}, 32'(div0), 32'(d_exp));
    endtask

    // Complete the output handshake and confirm return to IDLE
    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_taken_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_taken_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_div0", 32'(div0), 32'd0);

        issue(3'd5, 8'd200, 8'd100); expect_result("add_carry", 1, 8'd44, 1'b1, 1'b0); take("add_carry");
        issue(3'd5, 8'd20, 8'd30);   expect_result("add", 1, 8'd50, 1'b0, 1'b0);       take("add");
        issue(3'd1, 8'h81, 8'd1);    expect_result("shl1", 1, 8'h02, 1'b0, 1'b0);      take("shl1");
        issue(3'd1, 8'hFF, 8'd8);    expect_result("shl8", 1, 8'h00, 1'b0, 1'b0);      take("shl8");
        issue(3'd4, 8'h80, 8'd7);    expect_result("shr7", 1, 8'h01, 1'b0, 1'b0);      take("shr7");
        issue(3'd4, 8'hFF, 8'd200);  expect_result("shr_big", 1, 8'h00, 1'b0, 1'b0);   take("shr_big");
        issue(3'd3, 8'hF0, 8'h3C);   expect_result("nand", 1, 8'hCF, 1'b0, 1'b0);      take("nand");
        issue(3'd0, 8'h0F, 8'h33);   expect_result("xor", 1, 8'h3C, 1'b0, 1'b0);       take("xor");
        issue(3'd7, 8'd200, 8'd7);   expect_result("div", 9, 8'd28, 1'b0, 1'b0);       take("div");
        issue(3'd2, 8'd200, 8'd7);   expect_result("mod", 9, 8'd4, 1'b0, 1'b0);        take("mod");
        issue(3'd7, 8'd255, 8'd1);   expect_result("div_by1", 9, 8'd255, 1'b0, 1'b0);  take("div_by1");
        issue(3'd2, 8'd5, 8'd9);     expect_result("mod_small", 9, 8'd5, 1'b0, 1'b0);  take("mod_small");
        issue(3'd7, 8'd55, 8'd0);    expect_result("div0", 1, 8'hFF, 1'b0, 1'b1);      take("div0");
        issue(3'd2, 8'd55, 8'd0);    expect_result("mod0", 1, 8'd55, 1'b0, 1'b1);      take("mod0");
        issue(3'd6, 8'd5, 8'd3);     expect_result("sub", 1, 8'd2, 1'b0, 1'b0);        take("sub");

        // Borrow result held while the consumer stalls
        issue(3'd6, 8'd3, 8'd5);     expect_result("sub_borrow", 1, 8'hFE, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_out", 32'(out), 32'hFE);
            check("hold_carry", 32'(carry), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        take("sub_borrow");

        // Reset during the 4th CALC cycle abandons the divide
        issue(3'd7, 8'd255, 8'd3);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out", 32'(out), 32'd0);
        repeat (10) begin
            @(negedge clk);
            check("midrst_no_result", 32'(out_valid), 32'd0);
        end
        issue(3'd0, 8'hAA, 8'hFF);   expect_result("xor_after_rst", 1, 8'h55, 1'b0, 1'b0);
        take("xor_after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipelined_alu_hs.md
Name: pipelined_alu_hs

Overview:
Parametrised successor to the team's single-cycle 4-op combinational ALU. Widens the opcode to 8 operations over WIDTH-bit operands, and adds a valid/ready handshake on input and output. Division and modulo run as a WIDTH-cycle iterative restoring divider. Sits between an operand-issue stage and a result-consumer stage; one operation in flight at a time.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand/opcode presented
in_ready  output  1  block can accept an operation
op  input  3  opcode, sampled on accept
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
out_valid  output  1  result available
out_ready  input  1  consumer takes result
out  output  WIDTH  result value
carry  output  1  carry-out (ADD) / borrow (SUB); 0 for other ops
div0  output  1  high with result when op is DIV or MOD and b == 0

Behaviour:
- Reset (sampled at rising edge while reset=1): state=IDLE, out=0, out_valid=0, carry=0, div0=0, internal divider regs=0. Reset dominates every other input in the same cycle. Reset mid-CALC or mid-DONE abandons the operation; no result is emitted.
- in_ready = (state == IDLE), combinational from state only.
- Accept = in_valid && in_ready at a rising edge; op/a/b are latched into internal regs. Later changes on op/a/b have no effect.
- Opcodes (A, B are latched values; all results are truncated to WIDTH bits):
  - 0 XOR: A ^ B.
  - 1 SHL: A << B; if B >= WIDTH, result is 0.
  - 2 MOD: A % B.
  - 3 NAND: ~(A & B).
  - 4 SHR: logical A >> B; if B >= WIDTH, result is 0.
  - 5 ADD: A + B; carry = bit WIDTH of the sum.
  - 6 SUB: A - B; carry = 1 when A < B (borrow).
  - 7 DIV: A / B, unsigned.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> DONE on accept of op in {0,1,3,4,5,6}; out/carry/div0 are registered on the same edge.
  - IDLE -> CALC on accept of op 2 or 7 with B != 0. Restoring divider performs one quotient bit per cycle, MSB first, for exactly WIDTH cycles in CALC.
  - CALC -> DONE after WIDTH iterations. out = quotient (DIV) or remainder (MOD).
  - IDLE -> DONE on op 2/7 with B == 0: div0=1. out = all-ones for DIV, out = A for MOD. No CALC cycles.
  - DONE -> IDLE when out_ready=1 at an edge (handshake completes).
- Latency from accept edge to first cycle out_valid=1:
  - Single-cycle ops and div-by-zero: 1 cycle.
  - DIV/MOD with B != 0: WIDTH+1 cycles.
- Throughput: at most one op per 2 cycles. No accept in the same cycle a result is taken, because in_ready=0 in DONE.
- out_valid = (state == DONE). While out_valid=1 and out_ready=0, out/carry/div0 hold stable indefinitely.
- carry=0 and div0=0 for all ops where they are not defined.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

Test Plan:
- WIDTH=8, reset held 2 cycles, then release -> in_ready=1, out_valid=0, out=0. Then op=5, a=200, b=100, accept -> next cycle out_valid=1, out=44, carry=1.
- op=1, a=0x81, b=1 -> out=0x02. op=1, a=0xFF, b=8 -> out=0x00. op=4, a=0x80, b=7 -> out=0x01. op=3, a=0xF0, b=0x3C -> out=0xCF.
- op=7, a=200, b=7 -> in_ready=0 for 9 cycles, then out_valid=1 with out=28, div0=0. op=2, a=200, b=7 -> out=4 after the same latency.
- op=7, a=55, b=0 -> 1 cycle later out=0xFF, div0=1. op=2, a=55, b=0 -> out=55, div0=1.
- op=6, a=3, b=5 -> out=0xFE, carry=1. Hold out_ready=0 for 10 cycles -> out_valid, out and carry unchanged and in_ready=0 throughout. Raise out_ready -> next cycle out_valid=0, in_ready=1.
- Accept op=7, a=255, b=3; assert reset on the 4th CALC cycle -> next cycle state=IDLE, out=0, out_valid=0. Then op=0, a=0xAA, b=0xFF -> out=0x55.
